code_lock_fsm: RTL and testbench

- Sequential combination-lock controller built around a 6-bit equality check.
- Captures a 6-bit guess through a valid/ready handshake and compares it with a stored secret code.
- On a match it opens the lock for a bounded time; on repeated mismatches it raises an alarm and locks out further guesses.
- Sits directly upstream of the lab's 6-bit equality comparator. It supplies the comparator's operands from registers and consumes its single "equal" result.

---
 rtl/code_lock_fsm_pkg.sv | 14 +
 rtl/code_lock_fsm_if.sv | 27 ++
 rtl/code_lock_fsm_code_match6.sv | 12 +
 rtl/code_lock_fsm.sv | 101 ++++++++++
 tb/tb_code_lock_fsm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/code_lock_fsm_pkg.sv
// rtl/code_lock_fsm_pkg.sv - shared state encoding and widths for the code lock
package code_lock_fsm_pkg;

  localparam int CODE_W  = 6;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/code_lock_fsm_if.sv
// rtl/code_lock_fsm_if.sv - guess handshake, code/relock controls and lock status bundle
interface code_lock_fsm_if;
  import code_lock_fsm_pkg::*;

  logic [CODE_W-1:0] guess;
  logic              guess_valid;
  logic              guess_ready;
  logic [CODE_W-1:0] new_code;
  logic              code_load;
  logic              relock;
  logic              unlocked;
  logic              alarm;
  logic              match_pulse;
  logic              mismatch_pulse;
  logic [2:0]        fail_count;

  modport master (
    output guess, guess_valid, new_code, code_load, relock,
    input  guess_ready, unlocked, alarm, match_pulse, mismatch_pulse, fail_count
  );

  modport slave (
    input  guess, guess_valid, new_code, code_load, relock,
    output guess_ready, unlocked, alarm, match_pulse, mismatch_pulse, fail_count
  );

endinterface

// File: rtl/code_lock_fsm_code_match6.sv
// rtl/code_lock_fsm_code_match6.sv - combinational 6-bit equality (per-bit xnor, and-reduce)
module code_match6
  import code_lock_fsm_pkg::*;
(
  input  logic [CODE_W-1:0] a_i,
  input  logic [CODE_W-1:0] b_i,
  output logic              equal_o
);

  assign equal_o = &(a_i ~^ b_i);

endmodule

// File: rtl/code_lock_fsm.sv
// rtl/code_lock_fsm.sv - combination lock: guess capture, check, timed open and lockout
module code_lock_fsm
  import code_lock_fsm_pkg::*;
#(
  parameter logic [CODE_W-1:0] CODE_RESET     = 6'b101010,
  parameter int                MAX_TRIES      = 3,
  parameter int                UNLOCK_CYCLES  = 8,
  parameter int                LOCKOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  code_lock_fsm_if.slave     bus
);

  localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]         TRIES_LIMIT  = 3'(MAX_TRIES);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   guess_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [2:0]          fail_count_q;
  logic                match_pulse_q;
  logic                mismatch_pulse_q;
  logic                equal;
  logic [2:0]          fail_count_d;

  code_match6 u_match (
    .a_i     (guess_q),
    .b_i     (code_q),
    .equal_o (equal)
  );

  assign fail_count_d = fail_count_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      code_q           <= CODE_RESET;
      guess_q          <= '0;
      timer_q          <= '0;
      fail_count_q     <= '0;
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
    end else begin
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.guess_valid) begin
            guess_q <= bus.guess;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (equal) begin
            fail_count_q  <= '0;
            match_pulse_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= OPEN;
          end else begin
            fail_count_q     <= fail_count_d;
            mismatch_pulse_q <= 1'b1;
            if (fail_count_d == TRIES_LIMIT) begin
              timer_q <= '0;
              state_q <= LOCKOUT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OPEN: begin
          timer_q <= timer_q + 1'b1;
          if (bus.code_load) begin
            code_q <= bus.new_code;
          end
          // A simultaneous load still commits before the early relock.
          if (bus.relock || timer_q == UNLOCK_LAST) begin
            state_q <= IDLE;
          end
        end
        LOCKOUT: begin
          timer_q <= timer_q + 1'b1;
          if (timer_q == LOCKOUT_LAST) begin
            fail_count_q <= '0;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.guess_ready    = (state_q == IDLE);
  assign bus.unlocked       = (state_q == OPEN);
  assign bus.alarm          = (state_q == LOCKOUT);
  assign bus.match_pulse    = match_pulse_q;
  assign bus.mismatch_pulse = mismatch_pulse_q;
  assign bus.fail_count     = fail_count_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb/tb_code_lock_fsm.sv - directed and random stimulus against a countdown reference model
module tb_code_lock_fsm;

  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam logic [5:0] SECRET = 6'b101010;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  code_lock_fsm_if bus_if ();

  code_lock_fsm #(
    .CODE_RESET     (SECRET),
    .MAX_TRIES      (MAX_TRIES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: the lock is described by remaining-cycle countdowns, not states.
  logic [5:0] m_code;
  logic [5:0] m_guess;
  bit         m_pending;
  int         m_open_left;
  int         m_lock_left;
  int         m_fails;
  bit         m_match;
  bit         m_mism;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [5:0] g, input bit ld,
                            input logic [5:0] nc, input bit rl, input bit rn);
    if (!rn) begin
      m_code = SECRET; m_guess = '0; m_pending = 0; m_open_left = 0;
      m_lock_left = 0; m_fails = 0; m_match = 0; m_mism = 0;
      return;
    end
    m_match = 0;
    m_mism  = 0;
    if (m_pending) begin
      m_pending = 0;
      if (m_guess == m_code) begin
        m_fails = 0; m_match = 1; m_open_left = UNLOCK_CYCLES;
      end else begin
        m_fails++; m_mism = 1;
        if (m_fails == MAX_TRIES) m_lock_left = LOCKOUT_CYCLES;
      end
    end else if (m_open_left > 0) begin
      if (ld) m_code = nc;
      m_open_left = rl ? 0 : m_open_left - 1;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (v) begin
      m_pending = 1;
      m_guess   = g;
    end
  endtask

  task automatic cyc(input bit v, input logic [5:0] g, input bit ld,
                     input logic [5:0] nc, input bit rl, input bit rn);
    @(negedge clk);
    check_eq("guess_ready", 8'(bus_if.guess_ready), 8'(!m_pending && m_open_left == 0 && m_lock_left == 0));
    check_eq("unlocked", 8'(bus_if.unlocked), 8'(m_open_left > 0));
    check_eq("alarm", 8'(bus_if.alarm), 8'(m_lock_left > 0));
    check_eq("match_pulse", 8'(bus_if.match_pulse), 8'(m_match));
    check_eq("mismatch_pulse", 8'(bus_if.mismatch_pulse), 8'(m_mism));
    check_eq("fail_count", 8'(bus_if.fail_count), 8'(m_fails));
    bus_if.guess_valid = v;
    bus_if.guess       = g;
    bus_if.code_load   = ld;
    bus_if.new_code    = nc;
    bus_if.relock      = rl;
    rst_n              = rn;
    model_step(v, g, ld, nc, rl, rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 6'h00, 0, 6'h00, 0, 1);
  endtask

  task automatic try_guess(input logic [5:0] g);
    cyc(1, g, 0, 6'h00, 0, 1);
    idle(2);
  endtask

  task automatic do_reset();
    cyc(0, 6'h00, 0, 6'h00, 0, 0);
  endtask

  initial begin
    bus_if.guess_valid = 0; bus_if.guess = '0; bus_if.code_load = 0;
    bus_if.new_code = '0; bus_if.relock = 0; rst_n = 0;
    model_step(0, 6'h00, 0, 6'h00, 0, 0);
    @(posedge clk);
    do_reset();
    idle(1);

    // Correct guess opens for the full window, then the lock returns to idle.
    try_guess(SECRET);
    idle(10);

    // Three misses trigger lockout; a guess during lockout is ignored.
    try_guess(6'h00);
    try_guess(6'h00);
    try_guess(6'h00);
    cyc(1, SECRET, 1, 6'h3F, 1, 1);
    idle(18);

    // Two misses then a match clears the count; one later miss has no alarm.
    try_guess(6'h01);
    try_guess(6'h02);
    try_guess(SECRET);
    idle(9);
    try_guess(6'h03);
    idle(1);

    // Load and relock together: new code takes effect, lock closes.
    try_guess(SECRET);
    cyc(0, 6'h00, 1, 6'b010101, 1, 1);
    idle(2);
    try_guess(SECRET);
    try_guess(6'b010101);
    idle(9);

    // Load and relock outside OPEN are ignored.
    do_reset();
    idle(1);
    cyc(0, 6'h00, 1, 6'h3F, 1, 1);
    cyc(0, 6'h00, 0, 6'h00, 1, 1);
    try_guess(SECRET);
    idle(9);

    // Reset mid-OPEN after a code change, and mid-LOCKOUT.
    try_guess(SECRET);
    cyc(0, 6'h00, 1, 6'h11, 0, 1);
    do_reset();
    idle(1);
    try_guess(SECRET);
    idle(2);
    do_reset();
    idle(1);
    for (int i = 0; i < MAX_TRIES; i++) try_guess(6'h00);
    idle(3);
    do_reset();
    idle(2);

    // Random traffic, biased toward hitting the current code.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] g;
      logic [5:0] nc;
      g  = ($urandom_range(0, 2) == 0) ? m_code : 6'($urandom);
      nc = ($urandom_range(0, 1) == 0) ? SECRET : 6'($urandom);
      cyc(($urandom_range(0, 2) != 0), g, ($urandom_range(0, 7) == 0), nc,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) != 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
